// File: rtl/alu4_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Holds the FSM state type, nibble width, index sizing and ALU op codes.
package alu4_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int NIBBLE_W = 4;

   // Function select/mode pairs for the 4-bit slice
   localparam logic [3:0] ALU_OP_ADD_SEL  = 4'h9;
   localparam logic       ALU_OP_ADD_MODE = 1'b0;
   localparam logic [3:0] ALU_OP_XOR_SEL  = 4'h6;
   localparam logic       ALU_OP_XOR_MODE = 1'b1;

   // Index register width; a single-nibble build still needs one bit
   function automatic int idx_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/alu4_seq_ctrl.sv
// Sequencer control: IDLE/RUN/DONE FSM, nibble index, handshakes.
// Ports: clk, rst_n, in_valid, out_ready in; in_ready, accept, run,
// last, out_valid, idx out.
module alu4_seq_ctrl
   import alu4_seq_pkg::*;
#(
   parameter int NIB   = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             accept,
   output logic             run,
   output logic             last,
   output logic             out_valid,
   output logic [IDX_W-1:0] idx
);

   state_t state;

   // DONE with a consuming downstream frees the slot this cycle
   assign in_ready = (state == IDLE) |
                     ((state == DONE) & out_ready);
   assign accept   = in_valid & in_ready;
   assign run      = (state == RUN);
   assign last     = run & (idx == IDX_W'(NIB - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  idx   <= '0;
               end
            end
            RUN: begin
               if (last) begin
                  state     <= DONE;
                  idx       <= '0;
                  out_valid <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  idx       <= '0;
                  if (accept) state <= RUN;
                  else        state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               idx       <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu4_nibble_sequencer.sv
// Multi-cycle WIDTH-bit operation built from a 4-bit ALU slice.
// Ports: in_* request (valid/ready), alu_* slice drive/capture,
// out_* result (valid/ready). Optional macro ALU_FLAGS_EN enables
// registered out_zero/out_neg; otherwise they are tied 0.
module alu4_nibble_sequencer
   import alu4_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_mode,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic             alu_cin,
   output logic [SEL_W-1:0] alu_sel,
   output logic             alu_mode,
   input  logic [3:0]       alu_f,
   input  logic             alu_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_cout,
   output logic             out_zero,
   output logic             out_neg
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int IDX_W = idx_width(NIB);

   logic             accept;
   logic             run;
   logic             last;
   logic [IDX_W-1:0] idx;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic [SEL_W-1:0] sel_q;
   logic             mode_q;
   logic             carry;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;

   alu4_seq_ctrl #(
      .NIB   (NIB),
      .IDX_W (IDX_W)
   ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .accept    (accept),
      .run       (run),
      .last      (last),
      .out_valid (out_valid),
      .idx       (idx)
   );

   // Slice is fed only from latched operands
   assign alu_a    = a_q[NIBBLE_W*idx +: NIBBLE_W];
   assign alu_b    = b_q[NIBBLE_W*idx +: NIBBLE_W];
   assign alu_cin  = (idx == '0) ? cin_q : carry;
   assign alu_sel  = sel_q;
   assign alu_mode = mode_q;

   // Result with the current slice nibble merged in; on the last
   // nibble this is the complete word loaded into out_data
   always_comb begin
      res_next = res;
      res_next[NIBBLE_W*idx +: NIBBLE_W] = alu_f;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         sel_q    <= '0;
         mode_q   <= 1'b0;
         carry    <= 1'b0;
         res      <= '0;
         out_data <= '0;
         out_cout <= 1'b0;
      end else begin
         if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            cin_q  <= in_cin;
            sel_q  <= in_sel;
            mode_q <= in_mode;
         end
         if (run) begin
            res   <= res_next;
            carry <= alu_cout;
         end
         // Separate output register keeps the result stable while
         // a back-to-back operation rebuilds res
         if (last) begin
            out_data <= res_next;
            out_cout <= alu_cout;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   logic zero_q;
   logic neg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (last) begin
         zero_q <= (res_next == '0);
         neg_q  <= res_next[WIDTH-1];
      end
   end

   assign out_zero = zero_q;
   assign out_neg  = neg_q;
`else
   assign out_zero = 1'b0;
   assign out_neg  = 1'b0;
`endif

endmodule
